// File: rtl/mc_ctrl_fsm.sv
// Multicycle control FSM: sequences fetch/decode/execute/mem/writeback for a shared-ALU datapath.
// Optional performance counters are enabled by defining MC_CTRL_PERF_CNT_EN.
module mc_ctrl_fsm #(
  parameter int MEM_TIMEOUT = 0,
  parameter int TO_W        = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic [2:0]  opcode,
  input  logic        change_pc,
  input  logic        mem_ack,
  output logic [2:0]  alu_opcode,
  output logic        alu_src_imm,
  output logic        ir_we,
  output logic        pc_we,
  output logic        pc_src,
  output logic        ab_we,
  output logic        aluout_we,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        mem_addr_sel,
  output logic        mdr_we,
  output logic        reg_we,
  output logic        wb_sel,
  output logic        instr_done,
  output logic        busy,
`ifdef MC_CTRL_PERF_CNT_EN
  output logic [31:0] cycle_cnt,
  output logic [31:0] instr_cnt,
`endif
  output logic        fault
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_FETCH     = 3'd1;
  localparam logic [2:0] S_DECODE    = 3'd2;
  localparam logic [2:0] S_EXECUTE   = 3'd3;
  localparam logic [2:0] S_MEM       = 3'd4;
  localparam logic [2:0] S_WRITEBACK = 3'd5;
  localparam logic [2:0] S_FAULT     = 3'd6;

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b100;

  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(MEM_TIMEOUT);

  logic [2:0]      state, state_nxt;
  logic [2:0]      boundary;
  logic [TO_W-1:0] to_cnt;
  logic            to_expire;

  assign boundary  = run ? S_FETCH : S_IDLE;
  // An ack arriving on the limit cycle wins over the timeout.
  assign to_expire = (MEM_TIMEOUT != 0) && (to_cnt == TO_LIMIT) && !mem_ack;

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    state_nxt    = state;
    alu_opcode   = 3'b000;
    alu_src_imm  = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_src       = 1'b0;
    ab_we        = 1'b0;
    aluout_we    = 1'b0;
    mem_rd       = 1'b0;
    mem_wr       = 1'b0;
    mem_addr_sel = 1'b0;
    mdr_we       = 1'b0;
    reg_we       = 1'b0;
    wb_sel       = 1'b0;
    instr_done   = 1'b0;
    busy         = 1'b0;
    fault        = 1'b0;
    case (state)
      S_IDLE: begin
        if (run) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        busy   = 1'b1;
        mem_rd = 1'b1;
        if (mem_ack) begin
          ir_we     = 1'b1;
          pc_we     = 1'b1;
          state_nxt = S_DECODE;
        end else if (to_expire) begin
          state_nxt = S_FAULT;
        end
      end
      S_DECODE: begin
        busy      = 1'b1;
        ab_we     = 1'b1;
        state_nxt = S_EXECUTE;
      end
      S_EXECUTE: begin
        busy = 1'b1;
        if (opcode[2]) begin
          alu_opcode = opcode;
          aluout_we  = 1'b1;
          state_nxt  = S_WRITEBACK;
        end else if (opcode[1]) begin
          alu_opcode = opcode;
          if (change_pc) begin
            pc_we  = 1'b1;
            pc_src = 1'b1;
          end
          instr_done = 1'b1;
          state_nxt  = boundary;
        end else begin
          // Address calculation: the ALU has no meaning for 000/001.
          alu_opcode  = OP_ADD;
          alu_src_imm = 1'b1;
          aluout_we   = 1'b1;
          state_nxt   = S_MEM;
        end
      end
      S_MEM: begin
        busy         = 1'b1;
        mem_addr_sel = 1'b1;
        mem_rd       = ~opcode[0];
        mem_wr       = opcode[0];
        if (mem_ack) begin
          if (opcode[0]) begin
            instr_done = 1'b1;
            state_nxt  = boundary;
          end else begin
            mdr_we    = 1'b1;
            state_nxt = S_WRITEBACK;
          end
        end else if (to_expire) begin
          state_nxt = S_FAULT;
        end
      end
      S_WRITEBACK: begin
        busy       = 1'b1;
        reg_we     = 1'b1;
        wb_sel     = (opcode == OP_LW);
        instr_done = 1'b1;
        state_nxt  = boundary;
      end
      S_FAULT: begin
        fault = 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Any state change clears the counter, which covers entry to FETCH and MEM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
    end else if (state_nxt != state) begin
      to_cnt <= '0;
    end else if ((state == S_FETCH || state == S_MEM) && !mem_ack) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

`ifdef MC_CTRL_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      if (busy)       cycle_cnt <= cycle_cnt + 32'd1;
      if (instr_done) instr_cnt <= instr_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Multicycle control FSM that sequences the shared ALU, instruction register, PC, register file and the single memory port, one instruction at a time.
- Decodes the 3-bit opcode held in the IR and drives the ALU opcode and all datapath write enables and selects, state by state.
- Sits between the instruction/data memory port and the datapath; the only controller of the ALU.

Parameters:
MEM_TIMEOUT, 0, cycles to wait for mem_ack before entering FAULT; 0 disables the timeout (wait forever)
TO_W, 8, width of the timeout counter; MEM_TIMEOUT must be < 2^TO_W

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
run  in  1  level; 1 = execute instructions, sampled at instruction boundaries only
opcode  in  3  IR[31:29]; 000 lw, 001 sw, 010 beq, 011 blt, 100 add, 101 sub, 110 and, 111 or
change_pc  in  1  ALU branch-taken flag
mem_ack  in  1  memory completes the current mem_rd/mem_wr this cycle
alu_opcode  out  3  opcode driven to the ALU
alu_src_imm  out  1  ALU operand 1 select: 0 = B register, 1 = sign-extended immediate
ir_we  out  1  load IR from memory read data
pc_we  out  1  load PC
pc_src  out  1  PC source: 0 = PC+4, 1 = branch target
ab_we  out  1  latch register-file outputs into A/B
aluout_we  out  1  latch ALU op_0 into ALUOut
mem_rd  out  1  memory read request
mem_wr  out  1  memory write request
mem_addr_sel  out  1  memory address: 0 = PC, 1 = ALUOut
mdr_we  out  1  latch memory read data into MDR
reg_we  out  1  register-file write
wb_sel  out  1  write-back data: 0 = ALUOut, 1 = MDR
instr_done  out  1  one-cycle pulse when an instruction retires
busy  out  1  1 in every state except IDLE and FAULT
fault  out  1  memory timeout; sticky until reset

Behaviour:
- Async reset: state = IDLE and timeout counter = 0. All outputs are 0 during and after reset until the FSM leaves IDLE.
- Outputs are combinational in state, opcode, change_pc and mem_ack. Every write enable and pc_we is a single-cycle pulse.
- Unlisted outputs are 0. alu_opcode is 000 outside EXECUTE.
- IDLE: if run = 1, go to FETCH.
- FETCH: mem_rd = 1, mem_addr_sel = 0.
  - On mem_ack: ir_we = 1, pc_we = 1, pc_src = 0, go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: ab_we = 1, go to EXECUTE.
- EXECUTE, R-type (1xx): alu_opcode = opcode, aluout_we = 1, go to WRITEBACK.
- EXECUTE, branch (01x): alu_opcode = opcode.
  - If change_pc = 1: pc_we = 1, pc_src = 1.
  - Then instr_done = 1, go to the boundary.
- EXECUTE, lw/sw (00x): alu_opcode = 100 (add), alu_src_imm = 1, aluout_we = 1, go to MEM.
  - Never pass 000/001 to the ALU; its output would hold stale data.
- MEM, lw: mem_rd = 1, mem_addr_sel = 1. On mem_ack: mdr_we = 1, go to WRITEBACK.
- MEM, sw: mem_wr = 1, mem_addr_sel = 1. On mem_ack: instr_done = 1, go to the boundary.
- WRITEBACK: reg_we = 1, wb_sel = 1 for lw, else 0. instr_done = 1, go to the boundary.
- Boundary: next state = FETCH if run = 1, else IDLE. Deasserting run never aborts an instruction in flight.
- mem_rd/mem_wr are held stable until mem_ack. A mem_ack outside FETCH/MEM is ignored.
- Timeout, when MEM_TIMEOUT > 0:
  - The counter clears on entry to FETCH or MEM and increments each cycle without ack.
  - When count = MEM_TIMEOUT and there is still no ack: go to FAULT.
  - FAULT: fault = 1, all other outputs 0, exits only via rst_n.
  - An ack on the same cycle the count reaches MEM_TIMEOUT wins; no fault.
- Total cycles per instruction, zero-wait memory: R-type 4, branch 3, sw 4, lw 5.

Optional Feature:
- Macro: MC_CTRL_PERF_CNT_EN.
- When defined: adds outputs cycle_cnt[31:0] and instr_cnt[31:0].
  - cycle_cnt increments every cycle busy = 1.
  - instr_cnt increments on each instr_done.
  - Both reset to 0 on rst_n and wrap modulo 2^32.
- When undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, run = 1, add (100), mem_ack = 1 every cycle -> FETCH, DECODE, EXECUTE, WRITEBACK; alu_opcode = 100 in EXECUTE; reg_we = 1 and instr_done = 1 on cycle 4.
- lw with mem_ack delayed 3 cycles in both FETCH and MEM -> mem_rd held high 4 cycles each; EXECUTE alu_opcode = 100 with alu_src_imm = 1; mdr_we then reg_we with wb_sel = 1; 11 cycles total.
- beq with change_pc = 1, then blt with change_pc = 0 -> first: pc_we = 1, pc_src = 1 in EXECUTE; second: only the fetch pc_we; each retires in 3 cycles.
- sw with run dropped during DECODE -> mem_wr = 1, mem_addr_sel = 1 until ack; instruction completes; FSM enters IDLE; busy = 0.
- MEM_TIMEOUT = 4, mem_ack never asserted in FETCH -> fault = 1 after 5 FETCH cycles, all enables 0; ack on the 5th cycle instead -> no fault.
- rst_n asserted while in MEM (lw) -> immediate IDLE, mem_rd = 0, no mdr_we/reg_we; with MC_CTRL_PERF_CNT_EN, both counters read 0.
